// File: rtl/irq_controller.sv
// Platform-level interrupt controller: synchronizes level sources, gates them by
// enable/priority/threshold, and exposes claim/complete over a valid/ready slave port.
module irq_controller #(
  parameter int unsigned SOURCES   = 8,
  parameter int unsigned PRIO_BITS = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [SOURCES-1:0] irq_src,
  input  logic               bus_valid,
  input  logic               bus_write,
  input  logic [7:0]         bus_address,
  input  logic [31:0]        bus_wdata,
  output logic [31:0]        bus_rdata,
  output logic               bus_ready,
  output logic               meip
);

  localparam logic [5:0] WORD_PENDING   = 6'h20;
  localparam logic [5:0] WORD_ENABLE    = 6'h21;
  localparam logic [5:0] WORD_THRESHOLD = 6'h22;
  localparam logic [5:0] WORD_CLAIM     = 6'h23;

  logic [PRIO_BITS-1:0] prio_q [1:SOURCES];
  logic [PRIO_BITS-1:0] prio_d [1:SOURCES];
  logic [SOURCES:1]     enable_q, enable_d;
  logic [SOURCES:1]     pending_q, pending_d;
  logic [SOURCES:1]     in_flight_q, in_flight_d;
  logic [SOURCES:1]     sync1_q, sync2_q;
  logic [PRIO_BITS-1:0] threshold_q, threshold_d;
  logic                 meip_q, meip_d;
  logic                 bus_ready_q, bus_ready_d;
  logic [31:0]          bus_rdata_q, bus_rdata_d;

  logic [4:0]           best_id;
  logic [PRIO_BITS-1:0] best_prio;
  logic [5:0]           word;
  logic                 accept;
  logic [31:0]          read_val;
  logic                 unused_bits;

  assign word        = bus_address[7:2];
  assign accept      = bus_valid & ~bus_ready_q;
  assign unused_bits = ^{bus_address[1:0], bus_wdata};

  // Seeding best_prio with the threshold enforces the strict priority > threshold
  // rule; the strict compare in an ascending scan gives ties to the lowest ID.
  always_comb begin
    best_id   = '0;
    best_prio = threshold_q;
    for (int unsigned i = 1; i <= SOURCES; i++) begin
      if (pending_q[i] && enable_q[i] && (prio_q[i] > best_prio)) begin
        best_id   = 5'(i);
        best_prio = prio_q[i];
      end
    end
  end

  always_comb begin
    read_val = '0;
    for (int unsigned i = 1; i <= SOURCES; i++) begin
      if (word == 6'(i)) read_val = 32'(prio_q[i]);
    end
    case (word)
      WORD_PENDING:   read_val = 32'({pending_q, 1'b0});
      WORD_ENABLE:    read_val = 32'({enable_q, 1'b0});
      WORD_THRESHOLD: read_val = 32'(threshold_q);
      WORD_CLAIM:     read_val = 32'(best_id);
      default:        ;
    endcase
  end

  always_comb begin
    prio_d      = prio_q;
    enable_d    = enable_q;
    threshold_d = threshold_q;
    pending_d   = pending_q   | (sync2_q & ~in_flight_q);
    in_flight_d = in_flight_q | (sync2_q & ~in_flight_q);
    meip_d      = (best_id != '0);
    bus_ready_d = accept;
    bus_rdata_d = accept ? read_val : '0;

    if (accept && !bus_write && (word == WORD_CLAIM)) begin
      for (int unsigned i = 1; i <= SOURCES; i++) begin
        if (best_id == 5'(i)) pending_d[i] = 1'b0;
      end
    end

    if (accept && bus_write) begin
      for (int unsigned i = 1; i <= SOURCES; i++) begin
        if (word == 6'(i)) prio_d[i] = bus_wdata[PRIO_BITS-1:0];
      end
      case (word)
        WORD_ENABLE:    enable_d    = bus_wdata[SOURCES:1];
        WORD_THRESHOLD: threshold_d = bus_wdata[PRIO_BITS-1:0];
        WORD_CLAIM: begin
          // Only an in-flight ID completes, so a same-edge gateway set is never undone.
          for (int unsigned i = 1; i <= SOURCES; i++) begin
            if ((bus_wdata[4:0] == 5'(i)) && in_flight_q[i]) in_flight_d[i] = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q      <= '{default: '0};
      enable_q    <= '0;
      threshold_q <= '0;
      pending_q   <= '0;
      in_flight_q <= '0;
      sync1_q     <= '0;
      sync2_q     <= '0;
      meip_q      <= 1'b0;
      bus_ready_q <= 1'b0;
      bus_rdata_q <= '0;
    end else begin
      prio_q      <= prio_d;
      enable_q    <= enable_d;
      threshold_q <= threshold_d;
      pending_q   <= pending_d;
      in_flight_q <= in_flight_d;
      sync1_q     <= irq_src;
      sync2_q     <= sync1_q;
      meip_q      <= meip_d;
      bus_ready_q <= bus_ready_d;
      bus_rdata_q <= bus_rdata_d;
    end
  end

  assign meip      = meip_q;
  assign bus_ready = bus_ready_q;
  assign bus_rdata = bus_rdata_q;

endmodule
